// File: rtl/up_counter_pkg.sv
// Shared types and constants for the up_counter timer block.
// Control priority ranks: a lower rank wins when several strobes are active in one cycle.
package up_counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned PRIO_LOAD  = 0;
  localparam int unsigned PRIO_HALT  = 1;
  localparam int unsigned PRIO_START = 2;
  localparam int unsigned PRIO_EN    = 3;

endpackage

// File: rtl/up_counter.sv
// Up counter with run/pause, clamped load, wrap and one-shot modes; all outputs registered, 1-cycle latency.
// No backpressure: every input is sampled on each rising clk edge and acted on immediately.
module up_counter
  import up_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAX   = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic             halt,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  if (MAX <= 0 || longint'(MAX) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
    $error("up_counter: MAX=%0d outside 1..2**WIDTH-1 for WIDTH=%0d", MAX, WIDTH);
  end

  if (!(PRIO_LOAD < PRIO_HALT && PRIO_HALT < PRIO_START && PRIO_START < PRIO_EN)) begin : g_bad_prio
    $error("up_counter: control priority ranks are not strictly ordered");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] load_clamped;

  // Out-of-range loads saturate at MAX rather than dropping high bits.
  assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    if (load) begin
      cnt_d   = load_clamped;
      state_d = IDLE;
    end else if (halt) begin
      if (state_q == COUNT) begin
        state_d = IDLE;
      end
    end else if (start && state_q != COUNT) begin
      if (state_q == DONE) begin
        cnt_d = '0;
      end
      state_d = COUNT;
    end else if (en && state_q == COUNT) begin
      if (cnt_q == MAX_V) begin
        tc_d = 1'b1;
        if (mode) begin
          state_d = DONE;
        end else begin
          cnt_d = '0;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      busy_q  <= (state_d == COUNT);
      done_q  <= (state_d == DONE);
    end
  end

  assign out  = cnt_q;
  assign tc   = tc_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_up_counter.sv
// Drives two up_counter instances (MAX=15 and MAX=9) with shared inputs and
// compares every cycle against a rule-level reference model.
module tb_up_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, start, halt, load, mode;
  logic [3:0] load_val;

  logic [3:0] out15, out9;
  logic       tc15, busy15, done15;
  logic       tc9, busy9, done9;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model: index 0 is the MAX=15 instance, index 1 the MAX=9 instance.
  int m_max [2] = '{15, 9};
  int m_out [2];
  bit m_run [2];
  bit m_fin [2];
  bit m_tc  [2];

  int tc15_seen;

  always #5 clk = ~clk;

  up_counter #(.WIDTH(4), .MAX(15)) u15 (
    .clk(clk), .reset(reset), .en(en), .start(start), .halt(halt), .load(load),
    .load_val(load_val), .mode(mode), .out(out15), .tc(tc15), .busy(busy15), .done(done15)
  );

  up_counter #(.WIDTH(4), .MAX(9)) u9 (
    .clk(clk), .reset(reset), .en(en), .start(start), .halt(halt), .load(load),
    .load_val(load_val), .mode(mode), .out(out9), .tc(tc9), .busy(busy9), .done(done9)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_out[i] = 0;
      m_run[i] = 1'b0;
      m_fin[i] = 1'b0;
      m_tc[i]  = 1'b0;
    end
  endtask

  // One clock edge of behaviour, straight from the control rules.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      m_tc[i] = 1'b0;
      if (load) begin
        m_out[i] = (int'(load_val) > m_max[i]) ? m_max[i] : int'(load_val);
        m_run[i] = 1'b0;
        m_fin[i] = 1'b0;
      end else if (halt) begin
        m_run[i] = 1'b0;
      end else if (start && !m_run[i]) begin
        if (m_fin[i]) m_out[i] = 0;
        m_fin[i] = 1'b0;
        m_run[i] = 1'b1;
      end else if (en && m_run[i]) begin
        if (m_out[i] == m_max[i]) begin
          m_tc[i] = 1'b1;
          if (mode) begin
            m_run[i] = 1'b0;
            m_fin[i] = 1'b1;
          end else begin
            m_out[i] = 0;
          end
        end else begin
          m_out[i] = m_out[i] + 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " out15"},  out15,          4'(m_out[0]));
    chk({tag, " tc15"},   {3'b0, tc15},   {3'b0, m_tc[0]});
    chk({tag, " busy15"}, {3'b0, busy15}, {3'b0, m_run[0]});
    chk({tag, " done15"}, {3'b0, done15}, {3'b0, m_fin[0]});
    chk({tag, " out9"},   out9,           4'(m_out[1]));
    chk({tag, " tc9"},    {3'b0, tc9},    {3'b0, m_tc[1]});
    chk({tag, " busy9"},  {3'b0, busy9},  {3'b0, m_run[1]});
    chk({tag, " done9"},  {3'b0, done9},  {3'b0, m_fin[1]});
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    if (tc15) tc15_seen++;
    check_all(tag);
  endtask

  task automatic drive(input string tag, input logic l, input logic [3:0] lv,
                       input logic h, input logic s, input logic e);
    load = l; load_val = lv; halt = h; start = s; en = e;
    tick(tag);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; start = 1'b0; halt = 1'b0; load = 1'b0;
    load_val = 4'd0; mode = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;
    drive("idle", 0, 0, 0, 0, 1);

    // Free-running wrap: start edge plus 19 en edges shows 0..15 then 0..3.
    tc15_seen = 0;
    drive("wrap_start", 0, 0, 0, 1, 1);
    for (int k = 0; k < 19; k++) drive("wrap", 0, 0, 0, 1, 1);
    chk("wrap_final15", out15, 4'd3);
    chk("wrap_tc_count15", 4'(tc15_seen), 4'd1);

    // One-shot on the MAX=9 instance.
    drive("clr", 1, 0, 0, 0, 0);
    mode = 1'b1;
    drive("os_start", 0, 0, 0, 1, 1);
    for (int k = 0; k < 12; k++) drive("oneshot", 0, 0, 0, 0, 1);
    chk("os_hold9", out9, 4'd9);
    chk("os_done9", {3'b0, done9}, 4'd1);
    drive("os_restart", 0, 0, 0, 1, 0);
    chk("os_restart_out9", out9, 4'd0);
    chk("os_restart_busy9", {3'b0, busy9}, 4'd1);

    // Load while counting, with clamping on the MAX=9 instance.
    mode = 1'b0;
    drive("clr", 1, 0, 0, 0, 0);
    drive("ld_start", 0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) drive("ld_count", 0, 0, 0, 0, 1);
    drive("ld_load", 1, 4'd12, 0, 0, 1);
    chk("ld_clamp9", out9, 4'd9);
    chk("ld_keep15", out15, 4'd12);

    // Priority: halt beats start and en at MAX; load beats start.
    drive("clr", 1, 0, 0, 0, 0);
    drive("pr_start", 0, 0, 0, 1, 0);
    for (int k = 0; k < 9; k++) drive("pr_count", 0, 0, 0, 0, 1);
    drive("pr_halt", 0, 0, 1, 1, 1);
    chk("pr_halt_tc9", {3'b0, tc9}, 4'd0);
    chk("pr_halt_out9", out9, 4'd9);
    drive("pr_ldstart", 1, 4'd3, 0, 1, 0);
    chk("pr_ldstart_busy9", {3'b0, busy9}, 4'd0);

    // en gating: 1,0,0,1 after start.
    drive("clr", 1, 0, 0, 0, 0);
    drive("gate_start", 0, 0, 0, 1, 0);
    drive("gate_e1", 0, 0, 0, 0, 1);
    drive("gate_e0", 0, 0, 0, 0, 0);
    drive("gate_e0", 0, 0, 0, 0, 0);
    drive("gate_e1", 0, 0, 0, 0, 1);
    chk("gate_out15", out15, 4'd2);

    // Asynchronous reset between edges at out=7.
    drive("clr", 1, 0, 0, 0, 0);
    drive("ar_start", 0, 0, 0, 1, 0);
    for (int k = 0; k < 7; k++) drive("ar_count", 0, 0, 0, 0, 1);
    chk("ar_at7", out15, 4'd7);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("ar_async");
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) drive("ar_after", 0, 0, 0, 0, 1);

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(31) == 0) mode = ~mode;
      drive("rand", $urandom_range(15) == 0, 4'($urandom_range(15)),
            $urandom_range(15) == 0, $urandom_range(3) == 0, $urandom_range(3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
